// File: rtl/hex_display_scheduler_if.sv
// Host/decoder-facing bundle of the HEX display scheduler: digit write port, blanking,
// shared-decoder loop (dec_value out, dec_seg back) and the latched segment outputs.
interface hex_display_scheduler_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    wr_en;
    logic [2:0]              wr_addr;
    logic [3:0]              wr_data;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              dec_value;
    logic [6:0]              dec_seg;
    logic [7*NUM_DIGITS-1:0] hex_out;
    logic                    frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, blank_mask, dec_seg,
        input  dec_value, hex_out, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, blank_mask, dec_seg,
        output dec_value, hex_out, frame_done
    );
endinterface

// File: rtl/hex_display_scheduler.sv
// Round-robin scheduler sharing one 7-segment decoder (decoder_de10_lite) across NUM_DIGITS HEX displays.
// Optional macro LEADING_ZERO_BLANK_EN: auto-blank leading zero digits (digit 0 always shown).

module decoder_de10_lite (
    input  logic [3:0] value,
    output logic [6:0] seg
);
    always_comb begin
        case (value)
            4'h0: seg = 7'b100_0000;
            4'h1: seg = 7'b111_1001;
            4'h2: seg = 7'b010_0100;
            4'h3: seg = 7'b011_0000;
            4'h4: seg = 7'b001_1001;
            4'h5: seg = 7'b001_0010;
            4'h6: seg = 7'b000_0010;
            4'h7: seg = 7'b111_1000;
            4'h8: seg = 7'b000_0000;
            4'h9: seg = 7'b001_0000;
            4'hA: seg = 7'b000_1000;
            4'hB: seg = 7'b000_0011;
            4'hC: seg = 7'b100_0110;
            4'hD: seg = 7'b010_0001;
            4'hE: seg = 7'b000_0110;
            default: seg = 7'b000_1110;
        endcase
    end
endmodule

// state   | meaning
// LOAD    | present digit_reg[idx] to the shared decoder (cnt = 0)
// CAPTURE | latch decoder output (or dark) into slice idx (cnt = 1)
// WAIT    | hold until the slot ends, then advance idx (cnt >= 2)
module hex_display_scheduler #(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_display_scheduler_if.slave bus
);
    localparam int             CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [2:0]     IDX_LAST = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {LOAD, CAPTURE, WAIT} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [2:0]              idx;
    logic [3:0]              digit_reg [NUM_DIGITS];
    logic [3:0]              dec_value_q;
    logic [7*NUM_DIGITS-1:0] hex_q;
    logic                    frame_done_q;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              cur_digit;
    logic                    cur_blank;
    logic                    slot_end;
    logic [2:0]              idx_next;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;
    logic                  run_zero;

    // run_zero stays set while every digit from the top down to i is zero
    always_comb begin
        lz       = '0;
        run_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero = run_zero && (digit_reg[i] == 4'h0);
            lz[i]    = run_zero;
        end
        lz[0] = 1'b0;
        blank = bus.blank_mask | lz;
    end
`else
    assign blank = bus.blank_mask;
`endif

    always_comb begin
        cur_digit = 4'h0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                cur_digit = digit_reg[i];
                cur_blank = blank[i];
            end
        end
    end

    assign slot_end = (cnt == CNT_LAST);
    assign idx_next = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= LOAD;
            cnt          <= '0;
            idx          <= 3'd0;
            dec_value_q  <= 4'h0;
            hex_q        <= '1;
            frame_done_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= 4'h0;
        end else begin
            frame_done_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bus.wr_en && (bus.wr_addr == 3'(i))) digit_reg[i] <= bus.wr_data;
            end
            case (state)
                LOAD: begin
                    dec_value_q <= cur_digit;
                    cnt         <= cnt + 1'b1;
                    state       <= CAPTURE;
                end
                CAPTURE, WAIT: begin
                    if (state == CAPTURE) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (idx == 3'(i)) hex_q[7*i +: 7] <= cur_blank ? 7'b111_1111 : bus.dec_seg;
                        end
                        frame_done_q <= (idx == IDX_LAST);
                    end
                    // with REFRESH_DIV=2 the capture slot is also the last one
                    if (slot_end) begin
                        cnt   <= '0;
                        idx   <= idx_next;
                        state <= LOAD;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= WAIT;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= LOAD;
                end
            endcase
        end
    end

    assign bus.dec_value  = dec_value_q;
    assign bus.hex_out    = hex_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed self-checking bench for hex_display_scheduler (NUM_DIGITS=6, REFRESH_DIV=4) with the DE10-Lite decoder.
module tb_hex_display_scheduler;
    localparam int ND    = 6;
    localparam int FRAME = 24;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] DARK = 7'b111_1111;
    localparam logic [6:0] S0   = 7'b100_0000;
    localparam logic [6:0] S2   = 7'b010_0100;
    localparam logic [6:0] S7   = 7'b111_1000;
    localparam logic [6:0] SA   = 7'b000_1000;
    localparam logic [6:0] SB   = 7'b000_0011;
    localparam logic [6:0] SC   = 7'b100_0110;
    localparam logic [6:0] SE   = 7'b000_0110;
    localparam logic [6:0] S9   = 7'b001_0000;
    localparam logic [6:0] SF   = 7'b000_1110;
    localparam logic [6:0] LZ   = LZB ? DARK : S0;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hex_display_scheduler_if #(.NUM_DIGITS(ND)) bus ();

    hex_display_scheduler #(.NUM_DIGITS(ND), .REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    decoder_de10_lite u_dec (
        .value (bus.dec_value),
        .seg   (bus.dec_seg)
    );

    typedef struct {
        logic [2:0] addr;
        logic [3:0] data;
        logic [6:0] seg;
    } vec_t;

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_digit(input logic [2:0] a, input logic [3:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        repeat (FRAME * n) @(posedge clk);
        @(negedge clk);
    endtask

    // count negedges until frame_done is seen high, bounded
    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < 60);
    endtask

    function automatic logic [41:0] pack6(input logic [6:0] s5, s4, s3, s2, s1, s0);
        return {s5, s4, s3, s2, s1, s0};
    endfunction

    vec_t        vecs [8];
    logic [41:0] exp_hex;
    int          n;
    int          total;

    initial begin
        vecs[0] = '{3'd5, 4'hF, SF};
        vecs[1] = '{3'd4, 4'h5, 7'b001_0010};
        vecs[2] = '{3'd3, 4'h3, 7'b011_0000};
        vecs[3] = '{3'd0, 4'h7, S7};
        vecs[4] = '{3'd1, 4'hA, SA};
        vecs[5] = '{3'd2, 4'hE, SE};
        vecs[6] = '{3'd4, 4'h9, S9};
        vecs[7] = '{3'd3, 4'hB, SB};

        rst_n          = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = 3'd0;
        bus.wr_data    = 4'h0;
        bus.blank_mask = '0;

        // reset state and frame timing
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hex_out", bus.hex_out, 42'h3FF_FFFF_FFFF);
        check("reset_frame_done", {41'b0, bus.frame_done}, 42'd0);
        check("reset_dec_value", {38'b0, bus.dec_value}, 42'd0);
        rst_n = 1'b1;
        wait_pulse(n);
        check("first_frame_done_within_24", {41'b0, (n >= 1 && n <= 24)}, 42'd1);
        wait_pulse(n);
        check("frame_period", 42'(n), 42'(FRAME));
        @(negedge clk);
        check("frame_done_one_cycle", {41'b0, bus.frame_done}, 42'd0);

        // table: write one digit, expect its slice after two frames
        exp_hex = {ND{LZ}};
        exp_hex[6:0] = S0;
        for (int i = 0; i < 8; i++) begin
            write_digit(vecs[i].addr, vecs[i].data);
            wait_frames(2);
            check($sformatf("vec%0d_slice%0d", i, vecs[i].addr),
                  {35'b0, bus.hex_out[7*vecs[i].addr +: 7]}, {35'b0, vecs[i].seg});
            exp_hex[7*vecs[i].addr +: 7] = vecs[i].seg;
        end
        check("table_full_hex", bus.hex_out, exp_hex);
        check("table_full_hex_const", exp_hex, pack6(SF, S9, SB, SE, SA, S7));

        // out-of-range addresses are ignored
        write_digit(3'd6, 4'h1);
        write_digit(3'd7, 4'h1);
        wait_frames(2);
        check("oob_write_ignored", bus.hex_out, pack6(SF, S9, SB, SE, SA, S7));

        // blank mask on digit 1, then cleared
        @(negedge clk);
        bus.blank_mask = 6'b000010;
        wait_frames(2);
        check("blank_mask_digit1", bus.hex_out, pack6(SF, S9, SB, SE, DARK, S7));
        bus.blank_mask = '0;
        wait_frames(1);
        check("unblank_within_frame", {35'b0, bus.hex_out[13:7]}, {35'b0, SA});

        // zero digits and leading-zero blanking
        for (int i = 5; i >= 1; i--) write_digit(3'(i), 4'h0);
        write_digit(3'd0, 4'hE);
        wait_frames(2);
        check("zeros_top_digit0_E", bus.hex_out, pack6(LZ, LZ, LZ, LZ, LZ, SE));
        write_digit(3'd3, 4'h2);
        wait_frames(2);
        check("inner_zeros_kept", bus.hex_out, pack6(LZ, LZ, S2, S0, S0, SE));
        write_digit(3'd3, 4'h0);
        write_digit(3'd0, 4'h0);
        wait_frames(2);
        check("all_zero_single_0", bus.hex_out, pack6(LZ, LZ, LZ, LZ, LZ, S0));

        // reset during WAIT of digit 3
        write_digit(3'd2, 4'hC);
        wait_frames(2);
        wait_pulse(n);
        check("pre_reset_frame_done", {41'b0, bus.frame_done}, 42'd1);
        repeat (16) @(posedge clk);
        @(negedge clk);
        exp_hex = LZB ? pack6(DARK, DARK, DARK, SC, S0, S0) : pack6(S0, S0, S0, SC, S0, S0);
        check("pre_reset_hex", bus.hex_out, exp_hex);
        rst_n = 1'b0;
        @(negedge clk);
        check("midscan_reset_dark", bus.hex_out, 42'h3FF_FFFF_FFFF);
        check("midscan_reset_frame_done", {41'b0, bus.frame_done}, 42'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("restart_at_idx0", bus.hex_out, pack6(DARK, DARK, DARK, DARK, DARK, S0));
        wait_pulse(n);
        total = n + 2;
        check("restart_frame_done_within_24", {41'b0, (bus.frame_done && total <= 24)}, 42'd1);
        wait_frames(1);
        check("restart_full_frame", bus.hex_out, pack6(LZ, LZ, LZ, LZ, LZ, S0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
